// File: rtl/page_quad_launch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : page_ctrl_pkg
// Purpose  : Shared command/state encodings for the quad page launch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package page_ctrl_pkg;

    localparam int NUM_PAGES = 4;

    typedef enum logic [1:0] {
        CMD_NOP    = 2'b00,
        CMD_LAUNCH = 2'b01,
        CMD_HALT   = 2'b10,
        CMD_RESEND = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RST    = 2'b01,
        SETTLE = 2'b10,
        RUN    = 2'b11
    } state_e;

endpackage
`default_nettype wire

// File: rtl/page_quad_launch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : page_quad_launch_ctrl_if
// Purpose  : Command channel and per-page control lines of the launch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface page_quad_launch_ctrl_if;
    import page_ctrl_pkg::*;

    logic                 cfg_valid;
    logic [1:0]           cfg_page;
    logic [1:0]           cfg_cmd;
    logic                 cfg_ready;
    logic [NUM_PAGES-1:0] page_reset;
    logic [NUM_PAGES-1:0] page_ap_start;
    logic [NUM_PAGES-1:0] page_resend;
    logic [NUM_PAGES-1:0] page_running;
    logic                 cmd_err;

    modport master (
        output cfg_valid, cfg_page, cfg_cmd,
        input  cfg_ready, page_reset, page_ap_start, page_resend, page_running, cmd_err
    );

    modport slave (
        input  cfg_valid, cfg_page, cfg_cmd,
        output cfg_ready, page_reset, page_ap_start, page_resend, page_running, cmd_err
    );

endinterface
`default_nettype wire

// File: rtl/page_quad_launch_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : page_launch_fsm
// Purpose  : Single-page reset/settle/run sequencer with registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module page_launch_fsm
    import page_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_cmd_stb,
    input  cmd_e i_cmd,
    output logic o_reset,
    output logic o_ap_start,
    output logic o_resend,
    output logic o_running,
    output logic o_busy,
    output logic o_illegal
);

    localparam logic [CNT_W-1:0] c_rst_load    = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_resend_nxt, w_illegal;
    logic             r_reset, r_ap_start, r_resend, r_running;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_resend_nxt = 1'b0;
        w_illegal    = 1'b0;

        // Leaving a phase on count==1 makes each phase exactly its load value long
        case (r_state)
            RST: begin
                if (r_cnt == c_one) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = c_settle_load;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            SETTLE: begin
                if (r_cnt == c_one) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            default: ;
        endcase

        if (i_cmd_stb) begin
            case (i_cmd)
                CMD_LAUNCH: begin
                    if (r_state == IDLE || r_state == RUN) begin
                        w_state_nxt = RST;
                        w_cnt_nxt   = c_rst_load;
                    end
                end
                CMD_HALT: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
                CMD_RESEND: begin
                    if (r_state == RUN) w_resend_nxt = 1'b1;
                    else                w_illegal    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_reset    <= 1'b1;
            r_ap_start <= 1'b0;
            r_resend   <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_reset    <= (w_state_nxt == IDLE) || (w_state_nxt == RST);
            r_ap_start <= (w_state_nxt == RUN);
            r_resend   <= w_resend_nxt;
            r_running  <= (w_state_nxt == RUN);
        end
    end

    assign o_reset    = r_reset;
    assign o_ap_start = r_ap_start;
    assign o_resend   = r_resend;
    assign o_running  = r_running;
    assign o_busy     = (r_state == RST) || (r_state == SETTLE);
    assign o_illegal  = w_illegal;

endmodule
`default_nettype wire

// File: rtl/page_quad_launch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : page_quad_launch_ctrl
// Purpose  : Launch sequencer for the four leaf pages of a quad region.
// Revision : 1.0 - initial release
// ============================================================================
module page_quad_launch_ctrl
    import page_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    page_quad_launch_ctrl_if.slave  bus
);

    logic [NUM_PAGES-1:0] w_stb, w_busy, w_illegal;
    logic [NUM_PAGES-1:0] w_rst, w_ap, w_resend, w_run;
    logic                 w_ready;
    logic                 r_cmd_err;

    // A LAUNCH may not restart a page that is still mid-sequence
    assign w_ready = !((cmd_e'(bus.cfg_cmd) == CMD_LAUNCH) && w_busy[bus.cfg_page]);

    generate
        for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_page
            localparam logic [1:0] c_idx = 2'(gi);

            assign w_stb[gi] = bus.cfg_valid && w_ready && (bus.cfg_page == c_idx);

            page_launch_fsm #(
                .RST_CYCLES    (RST_CYCLES),
                .SETTLE_CYCLES (SETTLE_CYCLES),
                .CNT_W         (CNT_W)
            ) u_fsm (
                .clk        (clk),
                .reset      (reset),
                .i_cmd_stb  (w_stb[gi]),
                .i_cmd      (cmd_e'(bus.cfg_cmd)),
                .o_reset    (w_rst[gi]),
                .o_ap_start (w_ap[gi]),
                .o_resend   (w_resend[gi]),
                .o_running  (w_run[gi]),
                .o_busy     (w_busy[gi]),
                .o_illegal  (w_illegal[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) r_cmd_err <= 1'b0;
        else       r_cmd_err <= r_cmd_err | (|w_illegal);
    end

    assign bus.cfg_ready     = w_ready;
    assign bus.page_reset    = w_rst;
    assign bus.page_ap_start = w_ap;
    assign bus.page_resend   = w_resend;
    assign bus.page_running  = w_run;
    assign bus.cmd_err       = r_cmd_err;

endmodule
`default_nettype wire
